i2c_slave_rx: RTL and testbench



---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_slave_rx_if.sv | 22 ++
 rtl/i2c_pin_sync.sv | 63 ++++++
 rtl/i2c_slave_rx.sv | 152 +++++++++++++++
 tb/tb_i2c_slave_rx.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants, state codes and address-match helper
package i2c_pkg;

    typedef logic [2:0] i2c_state_t;

    localparam i2c_state_t ST_IDLE      = 3'd0;
    localparam i2c_state_t ST_ADDR      = 3'd1;
    localparam i2c_state_t ST_ADDR_ACK  = 3'd2;
    localparam i2c_state_t ST_DATA      = 3'd3;
    localparam i2c_state_t ST_DATA_ACK  = 3'd4;
    localparam i2c_state_t ST_WAIT_STOP = 3'd5;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

    // Address byte is {addr[6:0], rw}; only writes to our address are answered.
    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] own);
        return (addr_byte[7:1] == own) && (addr_byte[0] == I2C_RW_WRITE);
    endfunction

endpackage

// File: rtl/i2c_slave_rx_if.sv
// rtl/i2c_slave_rx_if.sv - pin and received-byte stream bundle of the I2C target receiver
interface i2c_slave_rx_if;
    logic       i2c_scl;
    logic       i2c_sda_in;
    logic       i2c_sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       addr_match;
    logic       overrun;
    logic       busy;

    modport slave (
        input  i2c_scl, i2c_sda_in, rx_ready,
        output i2c_sda_oe, rx_data, rx_valid, addr_match, overrun, busy
    );

    modport master (
        output i2c_scl, i2c_sda_in, rx_ready,
        input  i2c_sda_oe, rx_data, rx_valid, addr_match, overrun, busy
    );
endinterface

// File: rtl/i2c_pin_sync.sv
// rtl/i2c_pin_sync.sv - 2-FF pin synchroniser, optional glitch filter (I2C_GLITCH_FILTER_EN), edge detect
module i2c_pin_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pin_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Output follows the pin only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if (sync_q[1] == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            cnt_q  <= '0;
            filt_q <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - I2C target write receiver; glitch filter enabled by I2C_GLITCH_FILTER_EN
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR   = 7'h3C,
    parameter int         FILTER_LEN = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    i2c_slave_rx_if.slave   bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_pin_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (bus.i2c_scl),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_pin_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (bus.i2c_sda_in),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic start_evt, stop_evt;
    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;

    i2c_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       sda_oe_q, sda_oe_d;
    logic       match_q, match_d;
    logic       ovr_q, ovr_d;
    logic       busy_q, busy_d;
    logic [7:0] shift_nxt;

    assign shift_nxt = {shift_q[6:0], sda_lvl};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sda_oe_d   = sda_oe_q;
        match_d    = match_q;
        ovr_d      = ovr_q;
        busy_d     = busy_q;

        if (start_evt) begin
            state_d  = ST_ADDR;
            cnt_d    = 3'd0;
            busy_d   = 1'b1;
            match_d  = 1'b0;
            ovr_d    = 1'b0;
            sda_oe_d = 1'b0;
        end else if (stop_evt) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            match_d  = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_nxt;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = addr_hit(shift_nxt, OWN_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // The driven ACK itself marks which falling edge we are on.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            match_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_DATA;
                            cnt_d    = 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_rise) begin
                        shift_d = shift_nxt;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (bus.rx_ready) begin
                                rx_data_d  = shift_nxt;
                                rx_valid_d = 1'b1;
                                state_d    = ST_DATA_ACK;
                            end else begin
                                ovr_d   = 1'b1;
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_WAIT_STOP: sda_oe_d = 1'b0;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            match_q    <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sda_oe_q   <= sda_oe_d;
            match_q    <= match_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.i2c_sda_oe = sda_oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.addr_match = match_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - table-driven and randomized bench for i2c_slave_rx
module tb_i2c_slave_rx;
    import i2c_pkg::*;

    localparam int         H   = 10;
    localparam logic [6:0] OWN = 7'h3C;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;
    logic rdy     = 1'b1;

    int vecs = 0;
    int errs = 0;

    i2c_slave_rx_if bus();

    i2c_slave_rx #(.OWN_ADDR(OWN), .FILTER_LEN(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.i2c_scl    = scl_drv;
    assign bus.i2c_sda_in = sda_drv & ~bus.i2c_sda_oe;
    assign bus.rx_ready   = rdy;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         oe_seen;

    always @(negedge clk) begin
        if (bus.rx_valid) got_q.push_back(bus.rx_data);
        if (bus.i2c_sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold();
        repeat (H) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; hold();
        scl_drv = 1'b1; hold();
        sda_drv = 1'b0; hold();
        scl_drv = 1'b0; hold();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; hold();
        scl_drv = 1'b1; hold();
        sda_drv = 1'b1; hold();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_drv = b[i]; hold();
            scl_drv = 1'b1; hold();
            scl_drv = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_drv = 1'b1; hold();
        scl_drv = 1'b1;
        repeat (H / 2) @(posedge clk);
        #1;
        ack = (bus.i2c_sda_in == I2C_ACK);
        repeat (H / 2) @(posedge clk);
        #1;
        scl_drv = 1'b0; hold();
    endtask

    // Master keeps clocking bytes even after a NACK so that ignoring them is exercised.
    task automatic run_txn(input logic [6:0] a, input logic rw, input int n, input logic [23:0] d,
                           input logic [2:0] rmask, output logic aack, output logic [2:0] dack,
                           output logic ovr, output logic match, output logic bsy);
        logic ack_i;
        got_q.delete();
        oe_seen = 1'b0;
        dack    = 3'b000;
        i2c_start();
        write_byte({a, rw}, aack);
        for (int i = 0; i < n; i++) begin
            rdy = rmask[i];
            write_byte(d[8*i +: 8], ack_i);
            dack[i] = ack_i;
        end
        ovr   = bus.overrun;
        match = bus.addr_match;
        bsy   = bus.busy;
        rdy   = 1'b1;
        i2c_stop();
        check("busy_after_stop", bus.busy, 0);
        check("match_after_stop", bus.addr_match, 0);
        check("oe_after_stop", bus.i2c_sda_oe, 0);
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        int          n;
        logic [23:0] d;
        logic [2:0]  rmask;
        logic        exp_aack;
        logic [2:0]  exp_dack;
        logic        exp_ovr;
        int          exp_nvalid;
        logic [7:0]  exp_last;
    } vec_t;

    vec_t       tbl[5];
    logic       aack, ovr, match, bsy, ack_i, m_aack, m_ovr, stopped;
    logic [2:0] dack, m_dack, rmask;
    logic [6:0] a;
    logic       rw;
    logic [23:0] d;
    int         n;

    initial begin
        tbl[0] = '{7'h3C, I2C_RW_WRITE, 1, 24'h0000A5, 3'b111, 1'b1, 3'b001, 1'b0, 1, 8'hA5};
        tbl[1] = '{7'h3D, I2C_RW_WRITE, 1, 24'h000011, 3'b111, 1'b0, 3'b000, 1'b0, 0, 8'h00};
        tbl[2] = '{7'h3C, I2C_RW_READ,  1, 24'h000022, 3'b111, 1'b0, 3'b000, 1'b0, 0, 8'h00};
        tbl[3] = '{7'h3C, I2C_RW_WRITE, 3, 24'h332211, 3'b111, 1'b1, 3'b111, 1'b0, 3, 8'h33};
        tbl[4] = '{7'h3C, I2C_RW_WRITE, 2, 24'h000201, 3'b001, 1'b1, 3'b001, 1'b1, 1, 8'h01};

        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_oe", bus.i2c_sda_oe, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_addr_match", bus.addr_match, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_busy", bus.busy, 0);
        reset_n = 1'b1;
        hold();

        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i].addr, tbl[i].rw, tbl[i].n, tbl[i].d, tbl[i].rmask, aack, dack, ovr, match, bsy);
            check($sformatf("tbl%0d_addr_ack", i), aack, tbl[i].exp_aack);
            check($sformatf("tbl%0d_data_ack", i), dack, tbl[i].exp_dack);
            check($sformatf("tbl%0d_overrun", i), ovr, tbl[i].exp_ovr);
            check($sformatf("tbl%0d_addr_match", i), match, tbl[i].exp_aack);
            check($sformatf("tbl%0d_busy", i), bsy, 1);
            check($sformatf("tbl%0d_oe_seen", i), oe_seen, tbl[i].exp_aack);
            check($sformatf("tbl%0d_nvalid", i), got_q.size(), tbl[i].exp_nvalid);
            check($sformatf("tbl%0d_last", i), (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'h00,
                  tbl[i].exp_last);
        end

        // Overrun survives STOP, is cleared by START; partial byte then repeated START.
        check("ovr_sticky_after_stop", bus.overrun, 1);
        got_q.delete();
        i2c_start();
        check("ovr_cleared_by_start", bus.overrun, 0);
        check("busy_after_start", bus.busy, 1);
        write_byte({OWN, I2C_RW_WRITE}, ack_i);
        check("rs_first_addr_ack", ack_i, 1);
        send_bits(8'hF0, 4);
        i2c_start();
        write_byte({OWN, I2C_RW_WRITE}, ack_i);
        check("rs_second_addr_ack", ack_i, 1);
        write_byte(8'h5A, ack_i);
        check("rs_data_ack", ack_i, 1);
        i2c_stop();
        check("rs_nvalid", got_q.size(), 1);
        check("rs_data", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'h5A);

        // Reset while the target is driving the data ACK.
        i2c_start();
        write_byte({OWN, I2C_RW_WRITE}, ack_i);
        send_bits(8'hAB, 8);
        sda_drv = 1'b1; hold();
        scl_drv = 1'b1;
        repeat (H / 2) @(posedge clk);
        #1;
        check("ack_oe_before_reset", bus.i2c_sda_oe, 1);
        reset_n = 1'b0;
        #1;
        check("reset_async_oe", bus.i2c_sda_oe, 0);
        check("reset_rx_data", bus.rx_data, 0);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_addr_match", bus.addr_match, 0);
        check("reset_overrun", bus.overrun, 0);
        check("reset_busy", bus.busy, 0);
        hold();
        reset_n = 1'b1;
        hold();
        run_txn(OWN, I2C_RW_WRITE, 1, 24'h000077, 3'b111, aack, dack, ovr, match, bsy);
        check("post_reset_addr_ack", aack, 1);
        check("post_reset_data_ack", dack, 3'b001);
        check("post_reset_nvalid", got_q.size(), 1);
        check("post_reset_data", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'h77);

        // Randomized transactions against a byte-level model of the target.
        for (int t = 0; t < 25; t++) begin
            a     = ($urandom_range(0, 3) == 3) ? 7'($urandom) : OWN;
            rw    = ($urandom_range(0, 3) == 0) ? I2C_RW_READ : I2C_RW_WRITE;
            n     = $urandom_range(1, 3);
            d     = 24'($urandom);
            for (int i = 0; i < 3; i++) rmask[i] = ($urandom_range(0, 4) != 0);

            exp_q.delete();
            m_aack  = (a == OWN) && (rw == I2C_RW_WRITE);
            m_ovr   = 1'b0;
            m_dack  = 3'b000;
            stopped = !m_aack;
            for (int i = 0; i < n; i++) begin
                if (!stopped) begin
                    if (rmask[i]) begin
                        exp_q.push_back(d[8*i +: 8]);
                        m_dack[i] = 1'b1;
                    end else begin
                        m_ovr   = 1'b1;
                        stopped = 1'b1;
                    end
                end
            end

            run_txn(a, rw, n, d, rmask, aack, dack, ovr, match, bsy);
            check($sformatf("rnd%0d_addr_ack", t), aack, m_aack);
            check($sformatf("rnd%0d_data_ack", t), dack, m_dack);
            check($sformatf("rnd%0d_overrun", t), ovr, m_ovr);
            check($sformatf("rnd%0d_addr_match", t), match, m_aack);
            check($sformatf("rnd%0d_nvalid", t), got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                check($sformatf("rnd%0d_byte%0d", t, i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
